mult_div_unit: RTL and testbench

- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands (rs, rt) and produces the HI/LO pair.
- mfhi/mflo results return to the register-file write port through the normal writeback path.
- Supports MIPS mult, multu, div, divu, mthi and mtlo. Asserts busy so the hazard logic stalls dependent HI/LO accesses.

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// with a one-cycle sign fix-up before HI/LO are written.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 zero_q, zero_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH-1:0]     rs_abs, rt_abs;
    logic                 rs_neg, rt_neg;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            zero_q  <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            zero_q  <= zero_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        // op[0] clear means a signed operation
        rs_neg = ~op[0] & rs_data[WIDTH-1];
        rt_neg = ~op[0] & rt_data[WIDTH-1];
        rs_abs = rs_neg ? (~rs_data + 1'b1) : rs_data;
        rt_abs = rt_neg ? (~rt_data + 1'b1) : rt_data;

        // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        zero_d  = zero_q;
        b_d     = b_q;
        acc_d   = acc_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    neg_a_d = rs_neg;
                    neg_b_d = rt_neg;
                    zero_d  = (rt_data == '0);
                    b_d     = rt_abs;
                    acc_d   = {{WIDTH{1'b0}}, rs_abs};
                    count_d = '0;
                    state_d = StCalc;
                end else begin
                    if (hi_we) hi_d = rs_data;
                    if (lo_we) lo_d = rs_data;
                end
            end
            StCalc: begin
                acc_d   = op_q[1] ? div_next : mul_next;
                count_d = count_q + 1'b1;
                if (count_q == CntW'(ITER - 1)) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (zero_q) begin
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against an
// arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        hi_we, lo_we;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dbz = 1'b0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        m_dbz = 1'b0;
        case (o)
            2'b00: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'b10: begin
                if (b == 0) m_dbz = 1'b1;
                else begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
            end
            default: begin
                if (b == 0) m_dbz = 1'b1;
                else begin m_hi = a % b; m_lo = a / b; end
            end
        endcase
    endfunction

    // Called at a negedge; leaves the bench at the negedge of the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit we_with_start, input int glitch_at);
        int n;
        int busy_cnt;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        hi_we   = we_with_start;
        lo_we   = we_with_start;
        model(o, a, b);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("done_drops", {63'b0, done}, 64'd0);
        n = 1;
        busy_cnt = 0;
        while (!done && n < 60) begin
            if (busy) busy_cnt++;
            if (n == glitch_at) begin
                start = 1'b1; op = ~o; rs_data = $urandom; rt_data = $urandom;
                hi_we = 1'b1; lo_we = 1'b1;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("latency", 64'(n), 64'd34);
        chk("busy_cycles", 64'(busy_cnt), 64'd33);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        chk("dbz", {63'b0, div_by_zero}, {63'b0, m_dbz});
        chk("hi", {32'b0, hi}, {32'b0, m_hi});
        chk("lo", {32'b0, lo}, {32'b0, m_lo});
    endtask

    initial begin
        int   seen_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);

        do_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 0);
        chk("mult_hi_const", {32'b0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo_const", {32'b0, lo}, 64'hFFFF_FFFA);
        @(negedge clk);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        chk("multu_hi_const", {32'b0, hi}, 64'hFFFF_FFFE);
        chk("multu_lo_const", {32'b0, lo}, 64'h0000_0001);
        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 0);
        chk("div_lo_const", {32'b0, lo}, 64'hFFFF_FFFD);
        chk("div_hi_const", {32'b0, hi}, 64'hFFFF_FFFF);
        do_op(2'b11, 32'd100, 32'd7, 1'b0, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        chk("ovf_lo_const", {32'b0, lo}, 64'h8000_0000);

        // mthi / mtlo, then divide by zero leaves them intact
        @(negedge clk);
        rs_data = 32'h1234; hi_we = 1'b1;
        @(negedge clk);
        rs_data = 32'h5678; hi_we = 1'b0; lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        m_hi = 32'h1234; m_lo = 32'h5678;
        chk("mthi", {32'b0, hi}, 64'h1234);
        chk("mtlo", {32'b0, lo}, 64'h5678);
        do_op(2'b11, 32'd55, 32'd0, 1'b0, 0);
        chk("dbz_pulse", {63'b0, div_by_zero}, 64'd1);

        // Same-cycle start and mthi/mtlo: writes dropped
        do_op(2'b01, 32'd9, 32'd11, 1'b1, 0);
        // Start, mthi/mtlo and new operands while busy: ignored
        @(negedge clk);
        do_op(2'b00, 32'h7654_3210, 32'h8000_0001, 1'b0, 10);
        // Back-to-back start in the done cycle
        do_op(2'b01, 32'd3, 32'd5, 1'b0, 0);
        chk("b2b_lo", {32'b0, lo}, 64'd15);
        chk("b2b_hi", {32'b0, hi}, 64'd0);

        // Reset mid-divide aborts with no done pulse
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs_data = 32'd1000; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        seen_done = 0;
        repeat (20) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);

        // Randomized ops, mixing in small and zero divisors
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) rb = -rb;
            do_op(ro, ra, rb, ($urandom_range(0, 4) == 0), 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
